// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional DMEM_ARB_RR_EN selects round-robin arbitration in rr_arb2.
package dmem_arb_pkg;

   localparam int unsigned AW_DEF = 6;
   localparam int unsigned DW_DEF = 32;

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_e;

   typedef enum logic {
      REQ0,
      REQ1
   } req_id_e;

   // One-hot two-way grant to requester id.
   function automatic req_id_e gnt2id(input logic [1:0] g);
      return g[1] ? REQ1 : REQ0;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: fixed priority (requester 0 wins) by default,
// round-robin with a pointer register when DMEM_ARB_RR_EN is defined.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
   logic ptr_q;

   // Tie goes to the requester the pointer selects.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   // After a grant the pointer favours the requester that lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else if (adv_i) begin
         ptr_q <= gnt_o[0];
      end
   end
`else
   logic unused_arb;
   assign unused_arb = ^{clk_i, rst_ni, adv_i};

   // Requester 0 always wins a tie.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grant, one access cycle, ack.
// Define DMEM_ARB_RR_EN for round-robin instead of fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          req0_i,
   input  logic          req1_i,
   input  logic          we0_i,
   input  logic          we1_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wdata0_i,
   input  logic [DW-1:0] wdata1_i,
   output logic          gnt0_o,
   output logic          gnt1_o,
   output logic          ack0_o,
   output logic          ack1_o,
   output logic [DW-1:0] rdata0_o,
   output logic [DW-1:0] rdata1_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_write_o,
   output logic          mem_read_o,
   input  logic [DW-1:0] mem_rdata_i
);

   state_e        state_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   req_id_e       id_q;
   logic          ack0_q;
   logic          ack1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   logic [1:0]    arb_req;
   logic [1:0]    arb_gnt;
   logic          take;
   req_id_e       win;

   assign arb_req = {req1_i, req0_i};
   assign take    = (state_q == S_IDLE) & (|arb_req);
   assign win     = gnt2id(arb_gnt);

   rr_arb2 u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (arb_req),
      .adv_i  (take),
      .gnt_o  (arb_gnt)
   );

   // Grants only in IDLE and never while reset is held.
   assign gnt0_o = take & arb_gnt[0] & rst_ni;
   assign gnt1_o = take & arb_gnt[1] & rst_ni;

   // Memory sees only the latched command; strobes only in ACCESS,
   // and reset clears the state at once so no write can follow.
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_write_o = (state_q == S_ACCESS) & we_q;
   assign mem_read_o  = (state_q == S_ACCESS) & ~we_q;

   assign ack0_o   = ack0_q;
   assign ack1_o   = ack1_q;
   assign rdata0_o = rdata0_q;
   assign rdata1_o = rdata1_q;

   // FSM: latch the winner's command, access once, then ack the owner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         id_q     <= REQ0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (take) begin
                  id_q    <= win;
                  state_q <= S_ACCESS;
                  if (win == REQ1) begin
                     we_q    <= we1_i;
                     addr_q  <= addr1_i;
                     wdata_q <= wdata1_i;
                  end else begin
                     we_q    <= we0_i;
                     addr_q  <= addr0_i;
                     wdata_q <= wdata0_i;
                  end
               end
            end
            S_ACCESS: begin
               state_q <= S_IDLE;
               if (id_q == REQ1) begin
                  ack1_q <= 1'b1;
                  if (!we_q) rdata1_q <= mem_rdata_i;
               end else begin
                  ack0_q <= 1'b1;
                  if (!we_q) rdata0_q <= mem_rdata_i;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus a random
// phase checked every cycle against a cycle-scheduled transaction model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req0, req1, we0, we1;
   logic [5:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0_o, gnt1_o, ack0_o, ack1_o;
   logic [31:0] rdata0_o, rdata1_o;
   logic [5:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_write_o, mem_read_o;
   logic [31:0] mem_rdata_i;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wcnt = 0;

   typedef struct {
      logic        we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic        id;
   } cmd_t;

   typedef struct {
      logic        id;
      logic        rd;
      logic [31:0] data;
   } ack_t;

   cmd_t sched_acc [int];
   ack_t sched_ack [int];

   logic        m_ptr;
   logic [31:0] m_rd0, m_rd1, m_wd;
   logic [5:0]  m_addr;
   logic        pw_valid = 1'b0;
   logic [5:0]  pw_addr;
   logic [31:0] pw_data;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req0_i      (req0),
      .req1_i      (req1),
      .we0_i       (we0),
      .we1_i       (we1),
      .addr0_i     (addr0),
      .addr1_i     (addr1),
      .wdata0_i    (wdata0),
      .wdata1_i    (wdata1),
      .gnt0_o      (gnt0_o),
      .gnt1_o      (gnt1_o),
      .ack0_o      (ack0_o),
      .ack1_o      (ack1_o),
      .rdata0_o    (rdata0_o),
      .rdata1_o    (rdata1_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_write_o (mem_write_o),
      .mem_read_o  (mem_read_o),
      .mem_rdata_i (mem_rdata_i)
   );

   assign mem_rdata_i = mem[mem_addr_o];

   always @(posedge clk) begin
      if (mem_write_o) mem[mem_addr_o] <= mem_wdata_o;
   end

   always @(posedge clk) begin
      if (pw_valid && rst_ni) ref_mem[pw_addr] = pw_data;
      pw_valid = 1'b0;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference: a grant in cycle N schedules the access for N+1 and
   // the ack (with read data) for N+2.
   always @(negedge clk) begin
      logic busy, win, e_g0, e_g1, e_ack0, e_ack1, e_we, e_re;
      cmd_t a_cmd, g_cmd;
      ack_t a;
      if (mem_write_o) wcnt++;
      if (!rst_ni) begin
         sched_acc.delete();
         sched_ack.delete();
         pw_valid = 1'b0;
         m_rd0 = '0;
         m_rd1 = '0;
         m_addr = '0;
         m_wd = '0;
         m_ptr = 1'b0;
         chk("rst_ctl", {58'd0, gnt0_o, gnt1_o, ack0_o, ack1_o,
                         mem_write_o, mem_read_o}, 64'd0);
         chk("rst_rdata", {rdata0_o, rdata1_o}, 64'd0);
         chk("rst_mem", {26'd0, mem_addr_o, mem_wdata_o}, 64'd0);
      end else begin
         e_ack0 = 1'b0;
         e_ack1 = 1'b0;
         if (sched_ack.exists(cyc)) begin
            a = sched_ack[cyc];
            sched_ack.delete(cyc);
            if (a.id) begin
               e_ack1 = 1'b1;
               if (a.rd) m_rd1 = a.data;
            end else begin
               e_ack0 = 1'b1;
               if (a.rd) m_rd0 = a.data;
            end
         end
         busy = sched_acc.exists(cyc);
         e_we = 1'b0;
         e_re = 1'b0;
         if (busy) begin
            a_cmd = sched_acc[cyc];
            sched_acc.delete(cyc);
            m_addr = a_cmd.addr;
            m_wd = a_cmd.wdata;
            e_we = a_cmd.we;
            e_re = !a_cmd.we;
            if (a_cmd.we) begin
               pw_valid = 1'b1;
               pw_addr = a_cmd.addr;
               pw_data = a_cmd.wdata;
            end
            a.id = a_cmd.id;
            a.rd = !a_cmd.we;
            a.data = ref_mem[a_cmd.addr];
            sched_ack[cyc+1] = a;
         end
         e_g0 = 1'b0;
         e_g1 = 1'b0;
         if (!busy && (req0 || req1)) begin
`ifdef DMEM_ARB_RR_EN
            win = (req0 && req1) ? m_ptr : req1;
            m_ptr = !win;
`else
            win = !req0;
`endif
            e_g0 = !win;
            e_g1 = win;
            g_cmd.we = win ? we1 : we0;
            g_cmd.addr = win ? addr1 : addr0;
            g_cmd.wdata = win ? wdata1 : wdata0;
            g_cmd.id = win;
            sched_acc[cyc+1] = g_cmd;
         end
         chk("gnt", {62'd0, gnt1_o, gnt0_o}, {62'd0, e_g1, e_g0});
         chk("ack", {62'd0, ack1_o, ack0_o}, {62'd0, e_ack1, e_ack0});
         chk("rdata0", {32'd0, rdata0_o}, {32'd0, m_rd0});
         chk("rdata1", {32'd0, rdata1_o}, {32'd0, m_rd1});
         chk("mem_ctl", {62'd0, mem_write_o, mem_read_o},
             {62'd0, e_we, e_re});
         chk("mem_addr", {58'd0, mem_addr_o}, {58'd0, m_addr});
         chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, m_wd});
      end
      cyc++;
   end

   initial begin
      logic [3:0] wins;
      logic [3:0] exp_wins;
      logic sg0, sg1;
      int t, w0;
      rst_ni = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h01010101 * i + 32'h11;
         ref_mem[i] = mem[i];
      end
      mem[5] = 32'hDEADBEEF;
      ref_mem[5] = 32'hDEADBEEF;
      mem[10] = 32'h0;
      ref_mem[10] = 32'h0;
      repeat (3) cycle();
      rst_ni = 1'b1;
      cycle();

      // Single read of mem[5]
      req0 = 1; we0 = 0; addr0 = 6'd5;
      @(negedge clk);
      chk("t1_gnt0", {63'd0, gnt0_o}, 64'd1);
      cycle();
      req0 = 0;
      @(negedge clk);
      chk("t1_read", {63'd0, mem_read_o}, 64'd1);
      chk("t1_addr", {58'd0, mem_addr_o}, 64'd5);
      cycle();
      @(negedge clk);
      chk("t1_ack0", {63'd0, ack0_o}, 64'd1);
      chk("t1_rdata0", {32'd0, rdata0_o}, 64'hDEADBEEF);
      cycle();

      // Write addr 63 then read it back via requester 1
      w0 = wcnt;
      req1 = 1; we1 = 1; addr1 = 6'd63; wdata1 = 32'h12345678;
      @(negedge clk);
      chk("t2_gnt1w", {63'd0, gnt1_o}, 64'd1);
      cycle();
      we1 = 0;
      @(negedge clk);
      chk("t2_busy", {63'd0, gnt1_o}, 64'd0);
      cycle();
      @(negedge clk);
      chk("t2_ack_gnt", {62'd0, ack1_o, gnt1_o}, 64'd3);
      cycle();
      req1 = 0;
      @(negedge clk);
      cycle();
      @(negedge clk);
      chk("t2_ack1", {63'd0, ack1_o}, 64'd1);
      chk("t2_rdata1", {32'd0, rdata1_o}, 64'h12345678);
      chk("t2_wcnt", 64'(wcnt - w0), 64'd1);
      chk("t2_mem63", {32'd0, mem[63]}, 64'h12345678);
      cycle();

      // Simultaneous requests held for four grants
      req0 = 1; we0 = 0; addr0 = 6'd1;
      req1 = 1; we1 = 0; addr1 = 6'd2;
      wins = '0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         @(negedge clk);
         while (!gnt0_o && !gnt1_o && t < 10) begin
            @(negedge clk);
            t++;
         end
         chk("t3_timeout", 64'(t >= 10), 64'd0);
         wins[k] = gnt1_o;
      end
      cycle();
      req0 = 0; req1 = 0;
`ifdef DMEM_ARB_RR_EN
      exp_wins = 4'b1010;
`else
      exp_wins = 4'b0000;
`endif
      chk("t3_order", {60'd0, wins}, {60'd0, exp_wins});
      repeat (3) cycle();

      // Reset during a write access to addr 10
      req0 = 1; we0 = 1; addr0 = 6'd10; wdata0 = 32'hCAFEF00D;
      @(negedge clk);
      chk("t4_gnt0", {63'd0, gnt0_o}, 64'd1);
      cycle();
      req0 = 0;
      @(negedge clk);
      chk("t4_wr", {63'd0, mem_write_o}, 64'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t4_wr_off", {63'd0, mem_write_o}, 64'd0);
      cycle();
      chk("t4_mem10", {32'd0, mem[10]}, 64'd0);
      chk("t4_noack", {62'd0, ack0_o, ack1_o}, 64'd0);
      cycle();
      rst_ni = 1'b1;
      cycle();
      cycle();

      // req0 pulses during an ACCESS and drops
      req1 = 1; we1 = 0; addr1 = 6'd3;
      @(negedge clk);
      chk("t5_gnt1", {63'd0, gnt1_o}, 64'd1);
      cycle();
      req1 = 0;
      req0 = 1; we0 = 1; addr0 = 6'd7; wdata0 = 32'hBAD0BAD0;
      @(negedge clk);
      chk("t5_nog0", {63'd0, gnt0_o}, 64'd0);
      cycle();
      req0 = 0;
      @(negedge clk);
      chk("t5_idle", {60'd0, gnt0_o, ack0_o, mem_write_o, mem_read_o},
          64'd0);
      chk("t5_ack1", {63'd0, ack1_o}, 64'd1);
      cycle();
      @(negedge clk);
      chk("t5_quiet", {61'd0, ack0_o, mem_write_o, mem_read_o}, 64'd0);
      cycle();

      // Random traffic with occasional resets and abandoned requests
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         sg0 = gnt0_o;
         sg1 = gnt1_o;
         cycle();
         if (!rst_ni) rst_ni = 1'b1;
         else if ($urandom_range(249) == 0) rst_ni = 1'b0;
         if (req0) begin
            if (sg0 || $urandom_range(15) == 0) req0 = 0;
         end else if ($urandom_range(2) == 0) begin
            req0 = 1;
            we0 = 1'($urandom_range(1));
            addr0 = ($urandom_range(3) == 0) ? 6'd63
                                             : 6'($urandom_range(7));
            wdata0 = $urandom;
         end
         if (req1) begin
            if (sg1 || $urandom_range(15) == 0) req1 = 0;
         end else if ($urandom_range(2) == 0) begin
            req1 = 1;
            we1 = 1'($urandom_range(1));
            addr1 = ($urandom_range(3) == 0) ? 6'd63
                                             : 6'($urandom_range(7));
            wdata1 = $urandom;
         end
      end
      req0 = 0;
      req1 = 0;
      rst_ni = 1'b1;
      repeat (4) cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
